// File: rtl/grid_draw_sequencer_if.sv
// Handshake and pixel bus between the grid draw sequencer, its background and
// symbol drawers, and the VGA adapter. master = sequencer side.
interface grid_draw_sequencer_if;
  logic       start;
  logic       redraw;
  logic [5:0] redraw_idx;
  logic [2:0] sym_ofs;

  logic       bg_go;
  logic       bg_done;
  logic [7:0] bg_x;
  logic [6:0] bg_y;
  logic [2:0] bg_colour;
  logic       bg_plot;

  logic       cell_go;
  logic [7:0] cell_x;
  logic [6:0] cell_y;
  logic [2:0] cell_sym;
  logic       cell_done;
  logic [7:0] sym_x;
  logic [6:0] sym_y;
  logic [2:0] sym_colour;
  logic       sym_plot;

  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    input  start, redraw, redraw_idx, sym_ofs,
    input  bg_done, bg_x, bg_y, bg_colour, bg_plot,
    input  cell_done, sym_x, sym_y, sym_colour, sym_plot,
    output bg_go, cell_go, cell_x, cell_y, cell_sym,
    output x, y, colour, plot, busy, done
  );

  modport slave (
    output start, redraw, redraw_idx, sym_ofs,
    output bg_done, bg_x, bg_y, bg_colour, bg_plot,
    output cell_done, sym_x, sym_y, sym_colour, sym_plot,
    input  bg_go, cell_go, cell_x, cell_y, cell_sym,
    input  x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/grid_draw_sequencer.sv
// Screen drawing sequencer: one background pass, then every grid cell handed to
// the shared symbol drawer; single-cell redraw; registered pixel mux to the VGA.
module grid_draw_sequencer #(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int X0   = 50,
  parameter int Y0   = 30,
  parameter int DX   = 20,
  parameter int DY   = 20,
  parameter int NSYM = 3
) (
  input logic                   clk,
  input logic                   reset_n,
  grid_draw_sequencer_if.master bus
);
  localparam int NCELL = ROWS * COLS;

  if (ROWS < 1 || ROWS > 8 || COLS < 1 || COLS > 8 || NSYM < 1 || NSYM > 8) begin : g_bad_dims
    $error("grid_draw_sequencer: ROWS/COLS/NSYM must be in 1..8");
  end
  if (X0 + (COLS - 1) * DX > 159) begin : g_bad_x
    $error("grid_draw_sequencer: rightmost cell origin exceeds x=159");
  end
  if (Y0 + (ROWS - 1) * DY > 119) begin : g_bad_y
    $error("grid_draw_sequencer: bottom cell origin exceeds y=119");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_BG_REQ, S_BG_WAIT, S_CELL_REQ, S_CELL_WAIT, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] row_q, row_d, col_q, col_d;
  logic [5:0] idx_q, idx_d;
  logic       single_q, single_d;
  logic [2:0] ofs_q, ofs_d;
  logic [7:0] cell_x_q, cell_x_d;
  logic [6:0] cell_y_q, cell_y_d;
  logic [2:0] cell_sym_q, cell_sym_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       load;

  function automatic logic [7:0] x_of(logic [2:0] c);
    int v;
    v = X0 + int'(c) * DX;
    return v[7:0];
  endfunction

  function automatic logic [6:0] y_of(logic [2:0] r);
    int v;
    v = Y0 + int'(r) * DY;
    return v[6:0];
  endfunction

  function automatic logic [2:0] sym_of(logic [5:0] i, logic [2:0] o);
    int v;
    v = (int'(i) + int'(o)) % NSYM;
    return v[2:0];
  endfunction

  function automatic logic [2:0] row_of(logic [5:0] i);
    int v;
    v = int'(i) / COLS;
    return v[2:0];
  endfunction

  function automatic logic [2:0] col_of(logic [5:0] i);
    int v;
    v = int'(i) % COLS;
    return v[2:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      idx_q      <= '0;
      single_q   <= 1'b0;
      ofs_q      <= '0;
      cell_x_q   <= '0;
      cell_y_q   <= '0;
      cell_sym_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      idx_q      <= idx_d;
      single_q   <= single_d;
      ofs_q      <= ofs_d;
      cell_x_q   <= cell_x_d;
      cell_y_q   <= cell_y_d;
      cell_sym_q <= cell_sym_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
    end
  end

  // Next state; cell origin/symbol are registered on entry to CELL_REQ so they
  // stay stable for the drawer through CELL_WAIT.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    idx_d      = idx_q;
    single_d   = single_q;
    ofs_d      = ofs_q;
    cell_x_d   = cell_x_q;
    cell_y_d   = cell_y_q;
    cell_sym_d = cell_sym_q;
    load       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_BG_REQ;
          single_d = 1'b0;
          ofs_d    = bus.sym_ofs;
        end else if (bus.redraw && int'(bus.redraw_idx) < NCELL) begin
          state_d  = S_CELL_REQ;
          single_d = 1'b1;
          ofs_d    = bus.sym_ofs;
          idx_d    = bus.redraw_idx;
          row_d    = row_of(bus.redraw_idx);
          col_d    = col_of(bus.redraw_idx);
          load     = 1'b1;
        end
      end
      S_BG_REQ:  state_d = S_BG_WAIT;
      S_BG_WAIT: begin
        if (bus.bg_done) begin
          state_d = S_CELL_REQ;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          load    = 1'b1;
        end
      end
      S_CELL_REQ: state_d = S_CELL_WAIT;
      S_CELL_WAIT: begin
        if (bus.cell_done) begin
          if (single_q || idx_q == 6'(NCELL - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CELL_REQ;
            idx_d   = idx_q + 6'd1;
            load    = 1'b1;
            if (col_q == 3'(COLS - 1)) begin
              col_d = '0;
              row_d = row_q + 3'd1;
            end else begin
              col_d = col_q + 3'd1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      cell_x_d   = x_of(col_d);
      cell_y_d   = y_of(row_d);
      cell_sym_d = sym_of(idx_d, ofs_d);
    end
  end

  // Outputs: handshake strobes decode the state; pixel mux selects the drawer
  // that owns the screen in the current state.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    case (state_q)
      S_BG_WAIT: begin
        x_d      = bus.bg_x;
        y_d      = bus.bg_y;
        colour_d = bus.bg_colour;
        plot_d   = bus.bg_plot;
      end
      S_CELL_REQ, S_CELL_WAIT: begin
        x_d      = bus.sym_x;
        y_d      = bus.sym_y;
        colour_d = bus.sym_colour;
        plot_d   = bus.sym_plot;
      end
      default: ;
    endcase
  end

  assign bus.bg_go    = (state_q == S_BG_REQ);
  assign bus.cell_go  = (state_q == S_CELL_REQ);
  assign bus.busy     = (state_q == S_BG_REQ) || (state_q == S_BG_WAIT) ||
                        (state_q == S_CELL_REQ) || (state_q == S_CELL_WAIT);
  assign bus.done     = (state_q == S_DONE);
  assign bus.cell_x   = cell_x_q;
  assign bus.cell_y   = cell_y_q;
  assign bus.cell_sym = cell_sym_q;
  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.colour   = colour_q;
  assign bus.plot     = plot_q;
endmodule

// File: tb/tb_grid_draw_sequencer.sv
// Randomized self-checking bench for grid_draw_sequencer: drawer responders,
// an event monitor, and a cell-list reference model built from the grid rules.
module tb_grid_draw_sequencer;
  localparam int ROWS = 3, COLS = 3, X0 = 50, Y0 = 30, DX = 20, DY = 20, NSYM = 3;
  localparam int NCELL = ROWS * COLS;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  grid_draw_sequencer_if bus ();

  grid_draw_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .X0(X0), .Y0(Y0), .DX(DX), .DY(DY), .NSYM(NSYM)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    int x;
    int y;
    int sym;
  } cell_t;

  cell_t obs_q[$];
  cell_t exp_q[$];
  int bg_cnt = 0;
  int done_cnt = 0;
  int n_chk = 0;
  int n_err = 0;

  // Monitor: every drawer request and completion pulse seen on the bus.
  always @(negedge clk) begin
    if (bus.bg_go) bg_cnt <= bg_cnt + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.cell_go) obs_q.push_back('{int'(bus.cell_x), int'(bus.cell_y), int'(bus.cell_sym)});
  end

  task automatic check_eq(string tag, int obs, int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: cell i sits at column i%COLS, row i/COLS; symbol rotates by ofs.
  task automatic model_push(int i, int ofs);
    exp_q.push_back('{X0 + (i % COLS) * DX, Y0 + (i / COLS) * DY, (i + ofs) % NSYM});
  endtask

  task automatic model_full(int ofs);
    exp_q.delete();
    for (int i = 0; i < NCELL; i++) model_push(i, ofs);
  endtask

  task automatic compare_cells(string tag, int base);
    check_eq({tag, "_ncell"}, obs_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < obs_q.size()) begin
        check_eq($sformatf("%s_x%0d", tag, i), obs_q[base+i].x, exp_q[i].x);
        check_eq($sformatf("%s_y%0d", tag, i), obs_q[base+i].y, exp_q[i].y);
        check_eq($sformatf("%s_sym%0d", tag, i), obs_q[base+i].sym, exp_q[i].sym);
      end
    end
  endtask

  // which: 0 bg_go, 1 cell_go, 2 done. Returns at the negedge it was seen.
  task automatic wait_evt(int which, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if ((which == 0 && bus.bg_go) || (which == 1 && bus.cell_go) || (which == 2 && bus.done)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq($sformatf("timeout_evt%0d", which), 0, 1);
  endtask

  task automatic serve_bg(int d);
    repeat (d) @(posedge clk);
    #1 bus.bg_done = 1'b1;
    @(posedge clk);
    #1 bus.bg_done = 1'b0;
  endtask

  task automatic serve_cell(int d);
    repeat (d) @(posedge clk);
    #1 bus.cell_done = 1'b1;
    @(posedge clk);
    #1 bus.cell_done = 1'b0;
  endtask

  task automatic pulse_start(int ofs, bit with_redraw, int ridx);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.sym_ofs = 3'(ofs);
    bus.redraw = with_redraw;
    bus.redraw_idx = 6'(ridx);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.redraw = 1'b0;
    bus.sym_ofs = 3'($urandom_range(0, 7));
  endtask

  // cd == 0 selects a random drawer latency per cell.
  task automatic run_full(string tag, int ofs, int bgd, int cd, bit with_redraw, int ridx);
    int b_bg, b_obs, b_done;
    bit ok;
    b_bg = bg_cnt;
    b_obs = obs_q.size();
    b_done = done_cnt;
    model_full(ofs);
    pulse_start(ofs, with_redraw, ridx);
    wait_evt(0, ok);
    if (ok) begin
      serve_bg(bgd);
      for (int i = 0; i < NCELL; i++) begin
        wait_evt(1, ok);
        if (!ok) break;
        check_eq({tag, "_busy_cell"}, int'(bus.busy), 1);
        serve_cell(cd == 0 ? int'($urandom_range(1, 6)) : cd);
      end
      if (ok) begin
        wait_evt(2, ok);
        check_eq({tag, "_busy_done"}, int'(bus.busy), 0);
      end
    end
    @(posedge clk);
    #1;
    check_eq({tag, "_bg_go"}, bg_cnt - b_bg, 1);
    compare_cells(tag, b_obs);
    check_eq({tag, "_done"}, done_cnt - b_done, 1);
  endtask

  task automatic run_redraw(string tag, int idx, int ofs, bit inject_start);
    int b_bg, b_obs, b_done;
    bit ok;
    b_bg = bg_cnt;
    b_obs = obs_q.size();
    b_done = done_cnt;
    exp_q.delete();
    @(posedge clk);
    #1;
    bus.redraw = 1'b1;
    bus.redraw_idx = 6'(idx);
    bus.sym_ofs = 3'(ofs);
    @(posedge clk);
    #1;
    bus.redraw = 1'b0;
    bus.sym_ofs = 3'($urandom_range(0, 7));
    if (idx < NCELL) begin
      model_push(idx, ofs);
      wait_evt(1, ok);
      if (ok) begin
        check_eq({tag, "_busy_cell"}, int'(bus.busy), 1);
        if (inject_start) begin
          @(posedge clk);
          #1 bus.start = 1'b1;
          @(posedge clk);
          #1 bus.start = 1'b0;
        end
        serve_cell(int'($urandom_range(1, 6)));
        wait_evt(2, ok);
      end
      repeat (6) @(posedge clk);
      #1;
      check_eq({tag, "_busy_after"}, int'(bus.busy), 0);
      check_eq({tag, "_done"}, done_cnt - b_done, 1);
    end else begin
      for (int n = 0; n < 8; n++) begin
        @(negedge clk);
        check_eq({tag, "_busy_idle"}, int'(bus.busy), 0);
      end
      check_eq({tag, "_done"}, done_cnt - b_done, 0);
    end
    check_eq({tag, "_bg_go"}, bg_cnt - b_bg, 0);
    compare_cells(tag, b_obs);
  endtask

  task automatic test_pixels();
    bit ok;
    int rx, ry, rc;
    rx = 0;
    pulse_start(0, 1'b0, 0);
    wait_evt(0, ok);
    if (!ok) return;
    @(posedge clk);
    #1;
    bus.bg_x = 8'd3;
    bus.bg_y = 7'd4;
    bus.bg_colour = 3'd5;
    bus.bg_plot = 1'b1;
    @(posedge clk);
    #1;
    check_eq("pix_bg_x", int'(bus.x), 3);
    check_eq("pix_bg_y", int'(bus.y), 4);
    check_eq("pix_bg_colour", int'(bus.colour), 5);
    check_eq("pix_bg_plot", int'(bus.plot), 1);
    bus.bg_plot = 1'b0;
    bus.sym_plot = 1'b1;
    bus.sym_x = 8'd77;
    bus.sym_y = 7'd66;
    @(posedge clk);
    #1;
    check_eq("pix_sym_in_bg", int'(bus.plot), 0);
    bus.sym_plot = 1'b0;
    bus.bg_done = 1'b1;
    @(posedge clk);
    #1 bus.bg_done = 1'b0;
    for (int i = 0; i < NCELL; i++) begin
      wait_evt(1, ok);
      if (!ok) break;
      @(posedge clk);
      #1;
      rx = int'($urandom_range(0, 159));
      ry = int'($urandom_range(0, 119));
      rc = int'($urandom_range(0, 7));
      bus.sym_x = 8'(rx);
      bus.sym_y = 7'(ry);
      bus.sym_colour = 3'(rc);
      bus.sym_plot = 1'b1;
      @(posedge clk);
      #1;
      check_eq($sformatf("pix_sym_x%0d", i), int'(bus.x), rx);
      check_eq($sformatf("pix_sym_y%0d", i), int'(bus.y), ry);
      check_eq($sformatf("pix_sym_c%0d", i), int'(bus.colour), rc);
      check_eq($sformatf("pix_sym_plot%0d", i), int'(bus.plot), 1);
      bus.sym_plot = 1'b0;
      bus.cell_done = 1'b1;
      @(posedge clk);
      #1 bus.cell_done = 1'b0;
    end
    wait_evt(2, ok);
    @(posedge clk);
    #1;
    bus.bg_plot = 1'b1;
    bus.bg_x = 8'd99;
    bus.sym_plot = 1'b1;
    @(posedge clk);
    #1;
    check_eq("pix_idle_plot", int'(bus.plot), 0);
    check_eq("pix_idle_x_hold", int'(bus.x), rx);
    bus.bg_plot = 1'b0;
    bus.sym_plot = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    int b_done;
    b_done = done_cnt;
    pulse_start(0, 1'b0, 0);
    wait_evt(0, ok);
    if (!ok) return;
    serve_bg(2);
    bus.sym_x = 8'd11;
    bus.sym_y = 7'd12;
    bus.sym_colour = 3'd6;
    bus.sym_plot = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_evt(1, ok);
      if (!ok) return;
      serve_cell(2);
    end
    wait_evt(1, ok);
    if (!ok) return;
    @(posedge clk);
    #1;
    check_eq("rst_pre_plot", int'(bus.plot), 1);
    check_eq("rst_pre_cell_x", int'(bus.cell_x), X0 + DX);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_plot", int'(bus.plot), 0);
    check_eq("rst_x", int'(bus.x), 0);
    check_eq("rst_y", int'(bus.y), 0);
    check_eq("rst_colour", int'(bus.colour), 0);
    check_eq("rst_cell_x", int'(bus.cell_x), 0);
    check_eq("rst_cell_y", int'(bus.cell_y), 0);
    check_eq("rst_cell_sym", int'(bus.cell_sym), 0);
    check_eq("rst_go", int'(bus.cell_go) + int'(bus.bg_go) + int'(bus.done), 0);
    bus.sym_plot = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_no_done", done_cnt - b_done, 0);
    check_eq("rst_idle_busy", int'(bus.busy), 0);
    run_full("rst_restart", 1, 4, 0, 1'b0, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.redraw = 1'b0;
    bus.redraw_idx = '0;
    bus.sym_ofs = '0;
    bus.bg_done = 1'b0;
    bus.bg_x = '0;
    bus.bg_y = '0;
    bus.bg_colour = '0;
    bus.bg_plot = 1'b0;
    bus.cell_done = 1'b0;
    bus.sym_x = '0;
    bus.sym_y = '0;
    bus.sym_colour = '0;
    bus.sym_plot = 1'b0;
    reset_n = 1'b0;
    #12;
    check_eq("init_busy", int'(bus.busy), 0);
    check_eq("init_plot", int'(bus.plot), 0);
    check_eq("init_cell_x", int'(bus.cell_x), 0);
    check_eq("init_x", int'(bus.x), 0);
    check_eq("init_strobes", int'(bus.cell_go) + int'(bus.bg_go) + int'(bus.done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("init_idle_busy", int'(bus.busy), 0);

    run_full("full_ofs0", 0, 10, 5, 1'b0, 0);
    run_full("full_ofs2", 2, 10, 5, 1'b0, 0);
    run_redraw("redraw5", 5, 0, 1'b0);
    run_redraw("redraw9", 9, 0, 1'b0);
    run_redraw("redraw_start_busy", int'($urandom_range(0, NCELL - 1)), int'($urandom_range(0, 7)), 1'b1);
    run_full("start_and_redraw", 1, 3, 0, 1'b1, 4);
    test_pixels();
    test_reset();

    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        run_full($sformatf("rnd_full%0d", k), int'($urandom_range(0, 7)),
                 int'($urandom_range(1, 12)), 0, 1'b0, 0);
      end else begin
        run_redraw($sformatf("rnd_redraw%0d", k), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
